// File: rtl/alu_ctrl_pkg.sv
// Shared opcode constants, FSM state encoding and datapath defaults for the ALU sequencer.
package alu_ctrl_pkg;

  localparam int WIDTH = 16;
  localparam int CNT_W = 4;

  localparam logic [3:0] OP_AND  = 4'h0;
  localparam logic [3:0] OP_OR   = 4'h1;
  localparam logic [3:0] OP_NOR  = 4'h2;
  localparam logic [3:0] OP_XOR  = 4'h3;
  localparam logic [3:0] OP_XNOR = 4'h4;
  localparam logic [3:0] OP_NAND = 4'h5;
  localparam logic [3:0] OP_NOT  = 4'h6;
  localparam logic [3:0] OP_PASSB = 4'h7;
  localparam logic [3:0] OP_SHL  = 4'h8;
  localparam logic [3:0] OP_SHR  = 4'h9;
  localparam logic [3:0] OP_ROL  = 4'hA;
  localparam logic [3:0] OP_CLR  = 4'hB;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ROL);
  endfunction

  function automatic logic is_illegal(input logic [3:0] op);
    return op >= 4'hC;
  endfunction

endpackage

// File: rtl/alu_logic_unit.sv
// Combinational bitwise unit: (opcode, A, B) -> result for the single-cycle ops.
// Shift and illegal opcodes return zero; the sequencer handles those itself.
module alu_logic_unit
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = alu_ctrl_pkg::WIDTH
) (
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = '0;
    case (opcode)
      OP_AND:   result = a & b;
      OP_OR:    result = a | b;
      OP_NOR:   result = ~(a | b);
      OP_XOR:   result = a ^ b;
      OP_XNOR:  result = ~(a ^ b);
      OP_NAND:  result = ~(a & b);
      OP_NOT:   result = ~a;
      OP_PASSB: result = b;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// One-command-at-a-time ALU controller: bitwise ops take 1 cycle, shifts/rotates 1+k cycles.
// Result and flags are held in HOLD until out_ready; no new command is taken until then.
module alu_op_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = alu_ctrl_pkg::WIDTH,
  parameter int CNT_W = alu_ctrl_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             use_acc,
  input  logic             write_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             parity,
  output logic             err,
  output logic [WIDTH-1:0] acc
);

  state_t           state;
  logic [3:0]       op_q;
  logic             wacc_q;
  logic [WIDTH-1:0] work;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] lu_res;
  logic [WIDTH-1:0] fin_res;
  logic [WIDTH-1:0] work_nxt;
  logic [CNT_W-1:0] k;
  logic             illegal;
  logic             shift_op;

  assign a_sel    = use_acc ? acc : a;
  assign k        = b[CNT_W-1:0];
  assign illegal  = is_illegal(opcode);
  assign shift_op = is_shift(opcode);

  alu_logic_unit #(.WIDTH(WIDTH)) u_logic (
    .opcode (opcode),
    .a      (a_sel),
    .b      (b),
    .result (lu_res)
  );

  // A zero-length shift completes straight from IDLE with A unchanged.
  always_comb begin
    fin_res = lu_res;
    if (shift_op)
      fin_res = a_sel;
    else if (illegal)
      fin_res = '0;
  end

  always_comb begin
    work_nxt = {work[WIDTH-2:0], work[WIDTH-1]};
    case (op_q)
      OP_SHL:  work_nxt = work << 1;
      OP_SHR:  work_nxt = work >> 1;
      default: work_nxt = {work[WIDTH-2:0], work[WIDTH-1]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      parity    <= 1'b0;
      err       <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      work      <= '0;
      op_q      <= '0;
      wacc_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            op_q     <= opcode;
            wacc_q   <= write_acc;
            in_ready <= 1'b0;
            if (shift_op && (k != '0)) begin
              work  <= a_sel;
              cnt   <= k;
              state <= ST_SHIFT;
            end else begin
              result    <= fin_res;
              zero      <= (fin_res == '0);
              parity    <= ^fin_res;
              err       <= illegal;
              out_valid <= 1'b1;
              state     <= ST_HOLD;
              if (write_acc && !illegal)
                acc <= fin_res;
            end
          end
        end
        ST_SHIFT: begin
          work <= work_nxt;
          cnt  <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            result    <= work_nxt;
            zero      <= (work_nxt == '0);
            parity    <= ^work_nxt;
            err       <= 1'b0;
            out_valid <= 1'b1;
            state     <= ST_HOLD;
            if (wacc_q)
              acc <= work_nxt;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scenario bench for alu_op_sequencer with a queue of expected results built from a reference model.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  opcode;
  logic [15:0] a;
  logic [15:0] b;
  logic        use_acc;
  logic        write_acc;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        zero;
  logic        parity;
  logic        err;
  logic [15:0] acc;

  alu_op_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .a         (a),
    .b         (b),
    .use_acc   (use_acc),
    .write_acc (write_acc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .parity    (parity),
    .err       (err),
    .acc       (acc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    logic        z;
    logic        p;
    logic        e;
    logic [15:0] acc;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] acc_m;
  int          n_cmp = 0;
  int          n_bad = 0;

  // Values captured by collect()
  logic [15:0] c_res, c_acc;
  logic        c_z, c_p, c_e;
  int          c_lat;
  logic        c_stable, c_busy;

  function automatic exp_t model(input logic [3:0] op, input logic [15:0] av, input logic [15:0] bv);
    exp_t        x;
    int          kk;
    logic [15:0] r;
    kk = int'(bv[3:0]);
    r = 16'h0;
    x.e = 1'b0;
    x.lat = 1;
    case (op)
      4'h0: r = av & bv;
      4'h1: r = av | bv;
      4'h2: r = ~(av | bv);
      4'h3: r = av ^ bv;
      4'h4: r = ~(av ^ bv);
      4'h5: r = ~(av & bv);
      4'h6: r = ~av;
      4'h7: r = bv;
      4'h8: r = av << kk;
      4'h9: r = av >> kk;
      4'hA: r = (kk == 0) ? av : ((av << kk) | (av >> (16 - kk)));
      4'hB: r = 16'h0;
      default: begin r = 16'h0; x.e = 1'b1; end
    endcase
    if ((op == 4'h8 || op == 4'h9 || op == 4'hA) && kk > 0) x.lat = kk + 1;
    x.res = r;
    x.z = (r == 16'h0);
    x.p = ^r;
    x.acc = 16'h0;
    return x;
  endfunction

  task automatic send(input logic [3:0] op, input logic [15:0] av, input logic [15:0] bv,
                      input logic ua, input logic wa);
    exp_t x;
    int   g;
    x = model(op, ua ? acc_m : av, bv);
    if (wa && !x.e) acc_m = x.res;
    x.acc = acc_m;
    sb.push_back(x);
    opcode = op; a = av; b = bv; use_acc = ua; write_acc = wa; in_valid = 1'b1;
    g = 0;
    while (!in_ready && g < 50) begin @(posedge clk); #1; g++; end
    if (!in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Called right after the accept edge; waits for out_valid, optionally stalls, then handshakes.
  task automatic collect(input int hold);
    c_lat = 1;
    while (!out_valid && c_lat <= 40) begin @(posedge clk); #1; c_lat++; end
    c_res = result; c_z = zero; c_p = parity; c_e = err; c_acc = acc;
    c_stable = 1'b1; c_busy = 1'b1;
    if (!out_valid) return;
    for (int i = 0; i < hold; i++) begin
      out_ready = 1'b0;
      in_valid = 1'b1; opcode = 4'h0; a = 16'h5555; b = 16'h3333;
      @(posedge clk); #1;
      if (result !== c_res || zero !== c_z || parity !== c_p || err !== c_e || out_valid !== 1'b1)
        c_stable = 1'b0;
      if (in_ready !== 1'b0) c_busy = 1'b0;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if ({result, zero, parity, err} !== 19'h0) begin n_bad++;
      $display("FAIL reset_outputs: got res=%h z=%b p=%b e=%b want all 0", result, zero, parity, err); end
    n_cmp++; if (acc !== 16'h0) begin n_bad++; $display("FAIL reset_acc: got %h want 0000", acc); end
    rst = 1'b0;
    acc_m = 16'h0;
  endtask

  task automatic test_xor();
    exp_t x;
    send(4'h3, 16'hF0F0, 16'hFF00, 1'b0, 1'b0);
    collect(0);
    x = sb.pop_front();
    n_cmp++; if (c_lat !== 1) begin n_bad++; $display("FAIL xor_latency: got %0d want 1", c_lat); end
    n_cmp++; if (c_res !== 16'h0FF0 || c_res !== x.res) begin n_bad++; $display("FAIL xor_result: got %h want %h", c_res, x.res); end
    n_cmp++; if ({c_z, c_p, c_e} !== {x.z, x.p, x.e}) begin n_bad++;
      $display("FAIL xor_flags: got z=%b p=%b e=%b want %b%b%b", c_z, c_p, c_e, x.z, x.p, x.e); end
  endtask

  task automatic test_nor_backpressure();
    exp_t x;
    send(4'h2, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
    collect(5);
    x = sb.pop_front();
    n_cmp++; if (c_res !== x.res || c_z !== 1'b1) begin n_bad++; $display("FAIL nor_result: got %h z=%b want %h z=1", c_res, c_z, x.res); end
    n_cmp++; if (c_stable !== 1'b1) begin n_bad++; $display("FAIL nor_hold_stable: got %b want 1", c_stable); end
    n_cmp++; if (c_busy !== 1'b1) begin n_bad++; $display("FAIL nor_in_ready_low: got %b want 1", c_busy); end
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_bad++;
      $display("FAIL nor_after_handshake: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid); end
  endtask

  task automatic test_acc_chain();
    exp_t x;
    send(4'h7, 16'h0BAD, 16'h1234, 1'b0, 1'b1);
    collect(0);
    x = sb.pop_front();
    n_cmp++; if (c_res !== x.res || c_acc !== x.acc) begin n_bad++;
      $display("FAIL acc_pass: got res=%h acc=%h want %h %h", c_res, c_acc, x.res, x.acc); end
    send(4'h4, 16'hDEAD, 16'h1234, 1'b1, 1'b1);
    collect(0);
    x = sb.pop_front();
    n_cmp++; if (c_res !== 16'hFFFF || c_res !== x.res) begin n_bad++; $display("FAIL acc_xnor_result: got %h want %h", c_res, x.res); end
    n_cmp++; if (acc !== 16'hFFFF || acc !== x.acc) begin n_bad++; $display("FAIL acc_xnor_acc: got %h want %h", acc, x.acc); end
  endtask

  task automatic test_shifts();
    exp_t x;
    logic [3:0]  ops[3] = '{4'h8, 4'hA, 4'h9};
    logic [15:0] as[3]  = '{16'h0001, 16'h8001, 16'hABCD};
    logic [15:0] bs[3]  = '{16'h000F, 16'h0001, 16'h0000};
    int          lats[3] = '{16, 2, 1};
    for (int i = 0; i < 3; i++) begin
      send(ops[i], as[i], bs[i], 1'b0, 1'b0);
      collect(0);
      x = sb.pop_front();
      n_cmp++; if (c_lat !== lats[i] || c_lat !== x.lat) begin n_bad++; $display("FAIL shift%0d_latency: got %0d want %0d", i, c_lat, lats[i]); end
      n_cmp++; if (c_res !== x.res || c_z !== x.z || c_p !== x.p) begin n_bad++;
        $display("FAIL shift%0d_result: got %h z=%b p=%b want %h z=%b p=%b", i, c_res, c_z, c_p, x.res, x.z, x.p); end
    end
    for (int i = 0; i < 6; i++) begin
      send(4'(8 + (i % 3)), 16'($urandom), 16'($urandom), 1'b0, 1'b0);
      collect(i % 2);
      x = sb.pop_front();
      n_cmp++; if (c_res !== x.res || c_lat !== x.lat) begin n_bad++;
        $display("FAIL rshift%0d: got %h lat=%0d want %h lat=%0d", i, c_res, c_lat, x.res, x.lat); end
    end
  endtask

  task automatic test_illegal();
    exp_t x;
    send(4'hD, 16'h1111, 16'h2222, 1'b0, 1'b1);
    collect(0);
    x = sb.pop_front();
    n_cmp++; if (c_e !== 1'b1 || c_res !== 16'h0) begin n_bad++; $display("FAIL illegal_err: got err=%b res=%h want 1 0000", c_e, c_res); end
    n_cmp++; if (acc !== x.acc) begin n_bad++; $display("FAIL illegal_acc: got %h want %h", acc, x.acc); end
  endtask

  task automatic test_back_to_back();
    exp_t x;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++;
      $display("FAIL idle_out_ready: got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready); end
    for (int i = 0; i < 8; i++) begin
      send(4'($urandom_range(0, 11)), 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      collect(0);
      x = sb.pop_front();
      n_cmp++; if (c_res !== x.res || c_acc !== x.acc || c_e !== x.e || c_lat !== x.lat) begin n_bad++;
        $display("FAIL b2b%0d: got res=%h acc=%h e=%b lat=%0d want %h %h %b %0d",
                 i, c_res, c_acc, c_e, c_lat, x.res, x.acc, x.e, x.lat); end
    end
  endtask

  task automatic test_reset_mid_shift();
    exp_t x;
    logic late;
    send(4'h7, 16'h0, 16'h5A5A, 1'b0, 1'b1);
    collect(0);
    x = sb.pop_front();
    n_cmp++; if (acc !== 16'h5A5A || acc !== x.acc) begin n_bad++; $display("FAIL prereset_acc: got %h want %h", acc, x.acc); end
    send(4'h8, 16'h00FF, 16'h000A, 1'b0, 1'b1);
    void'(sb.pop_back());
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    acc_m = 16'h0;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++;
      $display("FAIL midshift_reset_ctrl: got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready); end
    n_cmp++; if (acc !== 16'h0) begin n_bad++; $display("FAIL midshift_reset_acc: got %h want 0000", acc); end
    late = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) late = 1'b1;
    end
    n_cmp++; if (late !== 1'b0) begin n_bad++; $display("FAIL midshift_late_valid: got %b want 0", late); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; opcode = 4'h0; a = 16'h0; b = 16'h0;
    use_acc = 1'b0; write_acc = 1'b0; out_ready = 1'b0; acc_m = 16'h0;
    test_reset();
    test_xor();
    test_nor_backpressure();
    test_acc_chain();
    test_shifts();
    test_illegal();
    test_back_to_back();
    test_reset_mid_shift();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Controller that sequences the 16-bit ALU logic datapath. It accepts one command at a time (opcode plus two operands) over a valid/ready handshake. Single-cycle bitwise ops complete directly; shift and rotate ops are iterated one bit per cycle. The result is held, with status flags, until the consumer accepts it. A 16-bit accumulator allows chained operations without re-supplying operand A.

Parameters:
WIDTH, 16, datapath width; operands, result and accumulator are WIDTH bits.
CNT_W, 4, width of the shift-amount field taken from b[CNT_W-1:0].

Ports:
clk  input  1  single system clock, rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  command present.
in_ready  output  1  sequencer can accept a command.
opcode  input  4  operation select.
a  input  WIDTH  operand A; ignored when use_acc=1.
b  input  WIDTH  operand B, or shift amount for shift ops.
use_acc  input  1  take operand A from the accumulator.
write_acc  input  1  write the result into the accumulator on completion.
out_valid  output  1  result and flags valid.
out_ready  input  1  consumer accepts the result.
result  output  WIDTH  operation result.
zero  output  1  result == 0.
parity  output  1  XOR-reduction of result.
err  output  1  opcode was illegal.
acc  output  WIDTH  current accumulator value.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (clk, rst).
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, zero=0, parity=0, err=0, acc=0, shift counter=0.
- A command is accepted when in_valid && in_ready at a rising edge. Operand A is latched as (use_acc ? acc : a), together with b, opcode and write_acc.
- Opcodes:
  - 0 AND, 1 OR, 2 NOR, 3 XOR, 4 XNOR, 5 NAND.
  - 6 NOT (~A), 7 PASS B, B CLR (result 0).
  - 8 SHL, 9 SHR (logical, zero fill), A ROL; amount k = b[3:0].
  - C-F illegal: result=0, err=1, accumulator never written.
- FSM states and transitions:
  - IDLE: in_ready=1. On accept:
    - non-shift op: compute via the logic unit, register result and flags, go to HOLD.
    - shift op with k=0: result=A, go to HOLD.
    - shift op with k>0: load working register with A and counter with k, go to SHIFT.
  - SHIFT: in_ready=0. Each cycle shift or rotate the working register by 1 and decrement the counter. When the counter reaches 1, register the final value, go to HOLD.
  - HOLD: out_valid=1 and in_ready=0. result/zero/parity/err stay stable until out_ready=1. The cycle out_valid && out_ready is the handshake; next state is IDLE.
- Latency from accept edge to out_valid:
  - single-cycle ops: 1 cycle.
  - shift ops: 1+k cycles for k>0 (max 16 at k=15); 1 cycle for k=0.
- Accumulator: written with the result when the op enters HOLD and the latched write_acc=1 and err=0. CLR with write_acc=1 zeroes acc. Old acc is visible on acc until that edge.
- Boundary conditions:
  - in_valid while in_ready=0: ignored, no queueing. The source must hold the command.
  - out_ready asserted outside HOLD: no effect.
  - Back-to-back commands: in_ready returns the cycle after the HOLD handshake, so the minimum command period is 2 cycles.
  - rst asserted in any state, including mid-SHIFT or HOLD: the next edge forces reset values. The in-flight op is discarded and acc is cleared.
  - Shifts and rotates are WIDTH-bit with no carry out. SHL/SHR by 15 leave one surviving bit. ROL by 16 is not expressible.

Decomposition:
- Shared package alu_ctrl_pkg:
  - opcode constants: OP_AND..OP_ROL, OP_CLR.
  - FSM state encoding: ST_IDLE, ST_SHIFT, ST_HOLD.
  - WIDTH default.
- Sub-module alu_logic_unit: purely combinational, (opcode, A, B) -> WIDTH-bit result, ops 0-7 and B. It is instantiated once in alu_op_sequencer. Shift iteration, flags and accumulator stay in the sequencer.

Test Plan:
- Reset then XOR: a=16'hF0F0, b=16'hFF00, opcode 3 -> out_valid 1 cycle after accept, result=16'h0FF0, zero=0, parity=0, err=0.
- NOR to zero with backpressure: a=16'hFFFF, b=16'h0000, out_ready held low 5 cycles -> result=16'h0000, zero=1; output and flags stable all 5 cycles; in_ready=0 until the cycle after the handshake.
- Accumulator chain: PASS b=16'h1234 with write_acc=1, then XNOR use_acc=1, b=16'h1234, write_acc=1 -> result=16'hFFFF, acc=16'hFFFF.
- Shifts:
  - SHL a=16'h0001, b=4'hF: out_valid exactly 16 cycles after accept, result=16'h8000.
  - ROL a=16'h8001, b=1: result=16'h0003, 2-cycle latency.
  - SHR with b=0: result=A, 1-cycle latency.
- Illegal and reset:
  - opcode 4'hD with write_acc=1 -> err=1, result=0, acc unchanged.
  - rst asserted mid-SHIFT (k=10, cycle 4) -> next cycle out_valid=0, in_ready=1, acc=0; no late out_valid appears.
